// File: rtl/mp_arith_pkg.sv
// Shared widths, types and helpers for the multi-precision arithmetic blocks
// (limb multiplier and sequential divider).
package mp_arith_pkg;

  localparam int N_BITS = 258;
  localparam int D_BITS = 130;

  // Poly1305 prime 2^130 - 5, the usual reduction modulus fed to the divider.
  localparam logic [D_BITS-1:0] P1305 = {D_BITS{1'b1}} - D_BITS'(4);

  typedef logic [N_BITS-1:0] dividend_t;
  typedef logic [D_BITS-1:0] divisor_t;
  typedef logic [D_BITS:0]   rem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_EARLY
  } div_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor when it fits, producing one quotient bit.
module div_step
  import mp_arith_pkg::*;
(
  input  logic [D_BITS-1:0] rem_i,
  input  logic [D_BITS-1:0] divisor_i,
  input  logic              bit_i,
  output logic [D_BITS-1:0] rem_o,
  output logic              qbit_o
);

  rem_t              shifted;
  logic [D_BITS+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

  // No borrow means shifted >= divisor; the difference is then below the
  // divisor, so bit D_BITS of it is zero as well.
  assign qbit_o = (diff[D_BITS+1:D_BITS] == 2'b00);
  assign rem_o  = qbit_o ? diff[D_BITS-1:0] : shifted[D_BITS-1:0];

endmodule

// File: rtl/div_258x130_seq.sv
// Sequential restoring divider, 258-bit / 130-bit, BITS_PER_CYCLE bits per clock.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module div_258x130_seq
  import mp_arith_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_BITS-1:0] dividend_in,
  input  logic [D_BITS-1:0] divisor_in,
  output logic [N_BITS-1:0] quotient_out,
  output logic [D_BITS-1:0] remainder_out,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  localparam int CYCLES = ceil_div(N_BITS, BITS_PER_CYCLE);
  localparam int W      = CYCLES * BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(CYCLES + 1);

  div_state_t        state_q, state_d;
  logic [W-1:0]      dq_q, dq_d, dq_step;
  logic [D_BITS-1:0] rem_q, rem_d;
  logic [D_BITS-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zdiv_q, zdiv_d;
  logic [N_BITS-1:0] quo_q, quo_d;
  logic [D_BITS-1:0] rmd_q, rmd_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;
  logic              early_lt;

  logic [D_BITS-1:0]         rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbits;

  assign rem_chain[0] = rem_q;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      div_step u_step (
        .rem_i     (rem_chain[gi]),
        .divisor_i (dvs_q),
        .bit_i     (dq_q[W-1-gi]),
        .rem_o     (rem_chain[gi+1]),
        .qbit_o    (qbits[BITS_PER_CYCLE-1-gi])
      );
    end
  endgenerate

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign dq_step = {dq_q[W-BITS_PER_CYCLE-1:0], qbits};

`ifdef DIV_EARLY_EXIT_EN
  assign early_lt = (dividend_in < N_BITS'(divisor_in));
`else
  assign early_lt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    zdiv_d  = zdiv_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dq_d    = W'(dividend_in);
          rem_d   = '0;
          dvs_d   = divisor_in;
          cnt_d   = '0;
          zdiv_d  = (divisor_in == '0);
          state_d = (zdiv_d || early_lt) ? ST_EARLY : ST_RUN;
        end
      end
      ST_RUN: begin
        dq_d  = dq_step;
        rem_d = rem_chain[BITS_PER_CYCLE];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          quo_d   = dq_step[N_BITS-1:0];
          rmd_d   = rem_chain[BITS_PER_CYCLE];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EARLY: begin
        quo_d   = zdiv_q ? '1 : '0;
        rmd_d   = dq_q[D_BITS-1:0];
        dbz_d   = zdiv_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      zdiv_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      zdiv_q  <= zdiv_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign quotient_out  = quo_q;
  assign remainder_out = rmd_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_div_258x130_seq.sv
// Scoreboard bench for div_258x130_seq: driver pushes model results, a
// monitor pops and compares on every done pulse.
module tb_div_258x130_seq;

  localparam int CYC = 129;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [257:0] dividend_in = '0;
  logic [129:0] divisor_in = '0;
  logic [257:0] quotient_out;
  logic [129:0] remainder_out;
  logic         busy, done, div_by_zero;

  div_258x130_seq dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [257:0] q;
    logic [129:0] r;
    logic         dbz;
    int           k;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_done = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [257:0] act, input logic [257:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: count edges and score every completion.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    edge_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no completion", edge_cnt);
      end else begin
        e = sb.pop_front();
        n_done++;
        check("quotient", quotient_out, e.q);
        check("remainder", 258'(remainder_out), 258'(e.r));
        check("div_by_zero", 258'(div_by_zero), 258'(e.dbz));
        check("latency", 258'(edge_cnt - e.k), 258'(e.lat));
        $display("op %0d: accept_edge=%0d latency=%0d q=%h r=%h dbz=%b",
                 n_done, e.k, edge_cnt - e.k, quotient_out, remainder_out, div_by_zero);
      end
    end
  end

  function automatic exp_t model(input logic [257:0] dvd, input logic [129:0] dvs);
    exp_t         e;
    logic [257:0] dw, rm;
    dw = 258'(dvs);
    if (dvs == '0) begin
      e.q   = '1;
      e.r   = dvd[129:0];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = dvd / dw;
      rm    = dvd % dw;
      e.r   = rm[129:0];
      e.dbz = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      e.lat = (dvd < dw) ? 1 : CYC;
`else
      e.lat = CYC;
`endif
    end
    e.k = 0;
    return e;
  endfunction

  task automatic do_op(input logic [257:0] dvd, input logic [129:0] dvs, output int k);
    exp_t e;
    int   waited;
    waited = 0;
    k = -1;
    @(negedge clk);
    while (busy && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", waited);
      return;
    end
    dividend_in = dvd;
    divisor_in  = dvs;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    k = edge_cnt;
    e = model(dvd, dvs);
    e.k = k;
    sb.push_back(e);
  endtask

  function automatic logic [257:0] rand_wide(input int nbits);
    logic [257:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = (v << 32) | 258'($urandom);
    if (nbits < 258) v &= (258'(1) << nbits) - 258'(1);
    return v;
  endfunction

  initial begin : stim
    int           k1, k2, nb;
    logic [257:0] a, tmp;
    logic [129:0] p, d;

    #12;
    check("reset_busy", 258'(busy), 258'(0));
    check("reset_done", 258'(done), 258'(0));
    check("reset_dbz", 258'(div_by_zero), 258'(0));
    check("reset_q", quotient_out, 258'(0));
    check("reset_r", 258'(remainder_out), 258'(0));
    @(negedge clk);
    reset_n = 1'b1;

    p = {130{1'b1}} - 130'd4;
    do_op(258'd100, 130'd7, k1);
    do_op(258'(1) << 130, p, k1);
    tmp = ((258'(1) << 128) - 258'(1));
    a = 258'(p) * tmp + 258'd3;
    do_op(a, p, k1);
    do_op('1, 130'd1, k1);
    do_op('1, {130{1'b1}}, k1);
    do_op(258'h1234, 130'd0, k1);
    do_op(258'd100, 130'd7, k1);

    // Back-to-back: second start lands in the done cycle of the first.
    do_op(258'd100, 130'd7, k1);
    do_op(258'd55, 130'd3, k2);
    check("no_gap_accept_edge", 258'(k2), 258'(k1 + CYC + 1));

    // Start while busy must be ignored.
    do_op(258'd100, 130'd7, k1);
    repeat (5) @(negedge clk);
    dividend_in = 258'd9;
    divisor_in  = 130'd2;
    start       = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;

    do_op(258'd3, 130'd10, k1);

    for (int i = 0; i < 20; i++) begin
      a   = rand_wide($urandom_range(1, 258));
      nb  = $urandom_range(0, 130);
      tmp = rand_wide(nb);
      d   = tmp[129:0];
      do_op(a, d, k1);
    end

    // Reset in the middle of an operation aborts it.
    do_op(258'd100, 130'd7, k1);
    repeat (59) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", 258'(busy), 258'(0));
    check("abort_done", 258'(done), 258'(0));
    check("abort_q", quotient_out, 258'(0));
    check("abort_r", 258'(remainder_out), 258'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_idle_busy", 258'(busy), 258'(0));

    do_op(258'd100, 130'd7, k1);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
